layer5_out_serializer: RTL and testbench

Reads the 120-element parallel result vector produced by the C5 convolution layer (one strobe per completed feature vector) and streams it out one signed element per beat to the F6 fully-connected layer over a valid/ready handshake. It holds one active vector plus one pending vector so a new C5 result arriving mid-stream is not lost. Elements are passed through bit-exact; no arithmetic is performed.

---
 rtl/layer5_out_serializer.sv | 135 +++++++++++++
 tb/tb_layer5_out_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer5_out_serializer.sv
// layer5_out_serializer: streams a C5 result vector to F6 one
// signed element per beat over valid/ready, with one pending slot.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_data, in_valid        parallel C5 vector and its one-cycle strobe
//   in_busy                  pending slot occupied
//   overflow                 sticky flag: a vector was dropped
//   out_data, out_index      current element and its index
//   out_last, out_valid      last-element marker, beat valid
//   out_ready                downstream accepts the beat
module layer5_out_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int OUTPUT_NUM = 120,
    parameter int IDX_WIDTH  = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*OUTPUT_NUM-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_busy,
    output logic                             overflow,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [IDX_WIDTH-1:0]             out_index,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_NUM - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] active_q [OUTPUT_NUM];
    logic [DATA_WIDTH-1:0] active_d [OUTPUT_NUM];
    logic [DATA_WIDTH-1:0] pend_q [OUTPUT_NUM];
    logic [DATA_WIDTH-1:0] pend_d [OUTPUT_NUM];
    logic [DATA_WIDTH-1:0] in_vec [OUTPUT_NUM];
    logic                  pend_full_q, pend_full_d;
    logic                  overflow_q, overflow_d;
    logic                  xfer;
    logic                  at_last;

    // Unpack the flat C5 bus into elements.
    always_comb begin
        for (int k = 0; k < OUTPUT_NUM; k++) begin
            in_vec[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign xfer    = (state_q == SEND) && out_ready;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    active_d = in_vec;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (xfer && at_last) begin
                    idx_d = '0;
                    if (pend_full_q) begin
                        // Pending moves up; a same-cycle vector refills it.
                        active_d = pend_q;
                        if (in_valid) begin
                            pend_d = in_vec;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (in_valid) begin
                        active_d = in_vec;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                    if (in_valid) begin
                        if (!pend_full_q) begin
                            pend_d      = in_vec;
                            pend_full_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int k = 0; k < OUTPUT_NUM; k++) begin
                active_q[k] <= '0;
                pend_q[k]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
            overflow_q  <= overflow_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_index = idx_q;
    assign out_last  = out_valid && at_last;
    assign out_data  = out_valid ? active_q[idx_q] : '0;
    assign in_busy   = pend_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_layer5_out_serializer.sv
// tb_layer5_out_serializer: randomized scoreboard bench for the
// C5-to-F6 serializer against a vector-queue reference model.
module tb_layer5_out_serializer;

    localparam int DW = 16;
    localparam int N  = 120;
    localparam int IW = 7;
    localparam int VW = DW * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_busy;
    logic          overflow;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;

    layer5_out_serializer #(
        .DATA_WIDTH(DW),
        .OUTPUT_NUM(N),
        .IDX_WIDTH (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_busy  (in_busy),
        .overflow (overflow),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: n vectors accepted but not fully sent (at most
    // two), r beats left of the head vector, ov sticky drop flag.
    int    n = 0;
    int    r = 0;
    bit    ov = 1'b0;
    bit    rst_hit = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] ramp_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(k - 60);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic push_vec(input logic [VW-1:0] v);
        beat_t b;
        for (int k = 0; k < N; k++) begin
            b.d = v[k*DW +: DW];
            b.i = IW'(k);
            b.l = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then check
    // the flags the model predicts for after the edge.
    task automatic step(input bit iv, input logic [VW-1:0] v,
                        input bit rdy);
        in_valid  = iv;
        in_data   = v;
        out_ready = rdy;
        if (n > 0 && rdy) begin
            r--;
            if (r == 0) begin
                n--;
                r = (n > 0) ? N : 0;
            end
        end
        if (iv) begin
            if (n < 2) begin
                n++;
                if (n == 1) r = N;
                push_vec(v);
            end else begin
                ov = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("in_busy", 64'(in_busy), 64'(n == 2));
        chk("overflow", 64'(overflow), 64'(ov));
        chk("out_valid", 64'(out_valid), 64'(n > 0));
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int c = 0; c < cycles; c++) step(1'b0, '0, rdy);
    endtask

    task automatic drain(input bit rand_rdy);
        int guard = 0;
        while (n > 0 && guard < 5000) begin
            step(1'b0, '0, rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1);
            guard++;
        end
        if (n > 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: %0d vectors left, need 0", n);
        end
        step(1'b0, '0, 1'b1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Advance with out_ready high until the head vector has
    // `left` beats remaining.
    task automatic run_to(input int left);
        int guard = 0;
        while (r != left && guard < 500) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        if (r != left) begin
            errors++;
            checks++;
            $display("FAIL run_to_timeout: r=%0d need %0d", r, left);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n  = 0;
        r  = 0;
        ov = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_busy", 64'(in_busy), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
    endtask

    always @(posedge clk) if (rst) rst_hit = 1'b1;

    // Monitor: compares every transferred beat against the scoreboard
    // and checks that a stalled beat holds steady.
    initial begin
        beat_t         b;
        bit            stalled = 1'b0;
        logic [DW-1:0] pd;
        logic [IW-1:0] pi;
        logic          pl;
        forever begin
            @(negedge clk);
            if (stalled && !rst_hit) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(pd));
                chk("stall_index", 64'(out_index), 64'(pi));
                chk("stall_last", 64'(out_last), 64'(pl));
            end
            rst_hit = 1'b0;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_beat: index %0d, none due",
                             out_index);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", 64'(out_data), 64'(b.d));
                    chk("beat_index", 64'(out_index), 64'(b.i));
                    chk("beat_last", 64'(out_last), 64'(b.l));
                end
            end
            stalled = !rst && out_valid && !out_ready;
            pd = out_data;
            pi = out_index;
            pl = out_last;
        end
    end

    initial begin
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] c;

        do_reset();

        // Ramp vector, ready always high.
        a = ramp_vec();
        step(1'b1, a, 1'b1);
        drain(1'b0);

        // Same vector, random backpressure.
        step(1'b1, a, bit'($urandom_range(0, 1)));
        drain(1'b1);

        // A, then B at beat 50: no drop, no bubble.
        a = rand_vec();
        b = rand_vec();
        step(1'b1, a, 1'b1);
        run_to(N - 50);
        step(1'b1, b, 1'b1);
        drain(1'b0);

        // A, B, C during A: C dropped, overflow sticky.
        a = rand_vec();
        b = rand_vec();
        c = rand_vec();
        step(1'b1, a, 1'b1);
        idle(10, 1'b1);
        step(1'b1, b, 1'b1);
        idle(30, 1'b1);
        step(1'b1, c, 1'b1);
        drain(1'b1);
        idle(5, 1'b1);
        do_reset();

        // New vector on A's last transfer, pending empty.
        a = rand_vec();
        b = rand_vec();
        step(1'b1, a, 1'b1);
        run_to(1);
        step(1'b1, b, 1'b1);
        chk("nogap_index", 64'(out_index), 64'd0);
        chk("nogap_data", 64'(out_data), 64'(b[DW-1:0]));
        drain(1'b0);

        // New vector on A's last transfer, pending full.
        a = rand_vec();
        b = rand_vec();
        c = rand_vec();
        step(1'b1, a, 1'b1);
        idle(5, 1'b1);
        step(1'b1, b, 1'b1);
        run_to(1);
        step(1'b1, c, 1'b1);
        chk("swap_data", 64'(out_data), 64'(b[DW-1:0]));
        drain(1'b0);

        // Reset at beat 37 with pending full, then a fresh vector.
        a = rand_vec();
        b = rand_vec();
        step(1'b1, a, 1'b1);
        idle(3, 1'b1);
        step(1'b1, b, 1'b1);
        run_to(N - 37);
        do_reset();
        idle(3, 1'b1);
        c = rand_vec();
        step(1'b1, c, 1'b1);
        drain(1'b0);

        // Random traffic with random backpressure.
        for (int c2 = 0; c2 < 3000; c2++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(1'b1, rand_vec(), $urandom_range(0, 3) != 0);
            end else begin
                step(1'b0, '0, $urandom_range(0, 3) != 0);
            end
        end
        drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
